// File: rtl/dm_abstract_cmd.sv
// -----------------------------------------------------------------------------
// dm_abstract_cmd
//   Abstract-command engine for the debug module. Accepts "Access Register"
//   commands (cmdtype 0) written to the DMI `command` register, checks that the
//   hart is halted, sequences one GPR/CSR read or write over the core debug
//   register port, and returns read data to data0. Owns abstractcs.busy and
//   the sticky abstractcs.cmderr field.
//
// Parameters
//   READ_LATENCY  cycles from RegAddr valid to RegOut valid (1..4)
//   NUM_GPR       GPRs reachable at regno 0x1000 .. 0x1000+NUM_GPR-1
//
// Ports
//   clk, reset_n   clock, asynchronous active-low reset
//   CmdValid       one-cycle pulse: DMI write to `command`
//   CmdWord        {cmdtype[31:24], aarsize[22:20], transfer[17], write[16], regno[15:0]}
//   Data0In        current data0 value (write data source)
//   CmdErrClr      W1C mask for cmderr
//   DebugMode      hart halted in debug mode
//   RegOut         core register read data
//   Busy           abstractcs.busy
//   CmdErr         abstractcs.cmderr (sticky)
//   Data0Out       read result for data0
//   Data0WE        one-cycle strobe: load Data0Out into data0
//   RegAddr        core register address (GPR index or CSR number)
//   RegIsGPR       1 = RegAddr selects a GPR, 0 = CSR
//   RegIn          write data to the core
//   DebugRegWrite  one-cycle core register write strobe
// -----------------------------------------------------------------------------
module dm_abstract_cmd #(
    parameter int READ_LATENCY = 1,
    parameter int NUM_GPR      = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        CmdValid,
    input  logic [31:0] CmdWord,
    input  logic [31:0] Data0In,
    input  logic [2:0]  CmdErrClr,
    input  logic        DebugMode,
    input  logic [31:0] RegOut,
    output logic        Busy,
    output logic [2:0]  CmdErr,
    output logic [31:0] Data0Out,
    output logic        Data0WE,
    output logic [11:0] RegAddr,
    output logic        RegIsGPR,
    output logic [31:0] RegIn,
    output logic        DebugRegWrite
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_CHECK     = 3'd1;
    localparam logic [2:0] S_WRITE     = 3'd2;
    localparam logic [2:0] S_READ_WAIT = 3'd3;
    localparam logic [2:0] S_DONE      = 3'd4;

    localparam logic [2:0] ERR_BUSY    = 3'd1;
    localparam logic [2:0] ERR_NOT_SUP = 3'd2;
    localparam logic [2:0] ERR_HALT    = 3'd4;

    localparam logic [15:0] GPR_FIRST = 16'h1000;
    localparam logic [15:0] GPR_LAST  = 16'(32'h1000 + NUM_GPR - 1);
    localparam logic [1:0]  WAIT_INIT = 2'(READ_LATENCY - 1);

    logic [2:0]  r_state;
    logic [7:0]  r_cmdtype;
    logic [2:0]  r_aarsize;
    logic        r_transfer;
    logic        r_write;
    logic [15:0] r_regno;
    logic [31:0] r_data0;
    logic [1:0]  r_wait_cnt;
    logic [2:0]  r_cmderr;
    logic [31:0] r_data0_out;
    logic        r_data0_we;
    logic [11:0] r_reg_addr;
    logic        r_reg_is_gpr;
    logic [31:0] r_reg_in;
    logic        r_reg_wr;

    logic        w_is_gpr;
    logic        w_is_csr;
    logic [2:0]  w_check_err;
    logic [2:0]  w_err_code;
    logic        w_unused_cmd_bits;

    // Bits 23 and 19:18 of the command (including postexec) are not acted on.
    assign w_unused_cmd_bits = ^{CmdWord[23], CmdWord[19:18]};

    assign w_is_gpr = (r_regno >= GPR_FIRST) && (r_regno <= GPR_LAST);
    assign w_is_csr = (r_regno <= 16'h0FFF);

    // Command validation, evaluated while in CHECK; first matching rule wins.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        w_check_err = 3'd0;
        if (r_cmdtype != 8'd0)
            w_check_err = ERR_NOT_SUP;
        else if (r_transfer && (r_aarsize != 3'd2))
            w_check_err = ERR_NOT_SUP;
        else if (r_transfer && !w_is_gpr && !w_is_csr)
            w_check_err = ERR_NOT_SUP;
        else if (!DebugMode)
            w_check_err = ERR_HALT;
    end

    // The in-flight command's own error outranks a busy collision in the same cycle.
    always_comb begin
        w_err_code = 3'd0;
        if ((r_state == S_CHECK) && (w_check_err != 3'd0))
            w_err_code = w_check_err;
        else if (CmdValid && (r_state != S_IDLE))
            w_err_code = ERR_BUSY;
    end

    // Sticky cmderr: only the first error is recorded, and a new error wins over
    // a same-cycle clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: sequential state uses non-blocking assignments only.
            r_cmderr <= 3'd0;
        end else if ((w_err_code != 3'd0) && (r_cmderr == 3'd0)) begin
            r_cmderr <= w_err_code;
        end else begin
            r_cmderr <= r_cmderr & ~CmdErrClr;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_cmdtype    <= 8'd0;
            r_aarsize    <= 3'd0;
            r_transfer   <= 1'b0;
            r_write      <= 1'b0;
            r_regno      <= 16'd0;
            r_data0      <= 32'd0;
            r_wait_cnt   <= 2'd0;
            r_data0_out  <= 32'd0;
            r_data0_we   <= 1'b0;
            r_reg_addr   <= 12'd0;
            r_reg_is_gpr <= 1'b0;
            r_reg_in     <= 32'd0;
            r_reg_wr     <= 1'b0;
        end else begin
            // Strobes default low; the state that raises one overrides below.
            r_data0_we <= 1'b0;
            r_reg_wr   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // A pending cmderr blocks new commands (pre-clear value).
                    if (CmdValid && (r_cmderr == 3'd0)) begin
                        r_cmdtype  <= CmdWord[31:24];
                        r_aarsize  <= CmdWord[22:20];
                        r_transfer <= CmdWord[17];
                        r_write    <= CmdWord[16];
                        r_regno    <= CmdWord[15:0];
                        r_data0    <= Data0In;
                        r_state    <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if ((w_check_err != 3'd0) || !r_transfer) begin
                        r_state <= S_DONE;
                    end else begin
                        r_reg_addr   <= w_is_gpr ? {7'b0, r_regno[4:0]} : r_regno[11:0];
                        r_reg_is_gpr <= w_is_gpr;
                        if (r_write) begin
                            r_reg_in <= r_data0;
                            r_reg_wr <= 1'b1;
                            r_state  <= S_WRITE;
                        end else begin
                            r_wait_cnt <= WAIT_INIT;
                            r_state    <= S_READ_WAIT;
                        end
                    end
                end
                S_WRITE: begin
                    r_state <= S_DONE;
                end
                S_READ_WAIT: begin
                    if (r_wait_cnt == 2'd0) begin
                        r_data0_out <= RegOut;
                        r_data0_we  <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 2'd1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign Busy          = (r_state != S_IDLE);
    assign CmdErr        = r_cmderr;
    assign Data0Out      = r_data0_out;
    assign Data0WE       = r_data0_we;
    assign RegAddr       = r_reg_addr;
    assign RegIsGPR      = r_reg_is_gpr;
    assign RegIn         = r_reg_in;
    assign DebugRegWrite = r_reg_wr;

endmodule

// File: tb/tb_dm_abstract_cmd.sv
// -----------------------------------------------------------------------------
// tb_dm_abstract_cmd
//   Self-checking bench for dm_abstract_cmd. A transaction-level model predicts,
//   per clock edge, busy/cmderr/strobes/data from the command rules; a compare
//   process checks the DUT every cycle. A simple core model answers register
//   reads with READ_LATENCY-1 pipeline stages and stores GPR writes.
// -----------------------------------------------------------------------------
module tb_dm_abstract_cmd;

    localparam int RL   = 2;
    localparam int NGPR = 32;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        CmdValid = 1'b0;
    logic [31:0] CmdWord = 32'd0;
    logic [31:0] Data0In = 32'd0;
    logic [2:0]  CmdErrClr = 3'd0;
    logic        DebugMode = 1'b0;
    logic [31:0] RegOut;
    logic        Busy;
    logic [2:0]  CmdErr;
    logic [31:0] Data0Out;
    logic        Data0WE;
    logic [11:0] RegAddr;
    logic        RegIsGPR;
    logic [31:0] RegIn;
    logic        DebugRegWrite;

    dm_abstract_cmd #(.READ_LATENCY(RL), .NUM_GPR(NGPR)) dut (
        .clk(clk), .reset_n(reset_n), .CmdValid(CmdValid), .CmdWord(CmdWord),
        .Data0In(Data0In), .CmdErrClr(CmdErrClr), .DebugMode(DebugMode),
        .RegOut(RegOut), .Busy(Busy), .CmdErr(CmdErr), .Data0Out(Data0Out),
        .Data0WE(Data0WE), .RegAddr(RegAddr), .RegIsGPR(RegIsGPR), .RegIn(RegIn),
        .DebugRegWrite(DebugRegWrite)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- register contents ----------------
    function automatic logic [31:0] csr_val(input logic [11:0] a);
        if (a == 12'h7B1) return 32'h8000_0004;
        return {a, 8'h5C, a};
    endfunction

    function automatic logic [31:0] gpr_init(input int i);
        if (i == 0) return 32'd0;
        return 32'hA000_0000 + 32'(i) * 32'h0001_0101;
    endfunction

    // ---------------- core model (environment) ----------------
    // One register stage gives RegOut valid RL=2 cycles after RegAddr.
    logic [31:0] core_gpr [NGPR];
    logic [31:0] core_q = 32'd0;
    always @(posedge clk) begin
        core_q <= RegIsGPR ? core_gpr[RegAddr[4:0]] : csr_val(RegAddr);
        if (DebugRegWrite && RegIsGPR && (RegAddr[4:0] != 5'd0))
            core_gpr[RegAddr[4:0]] <= RegIn;
    end
    assign RegOut = core_q;

    // ---------------- behavioural model ----------------
    int          cyc = 0;
    bit          m_busy;
    int          m_k, m_end, m_kind;   // kind: 0 none, 1 write, 2 read
    logic [31:0] m_cmd, m_data0, m_data0out, m_regin;
    logic [2:0]  m_cmderr;
    logic [11:0] m_addr;
    bit          m_gpr;
    bit          e_drw, e_we;
    logic [31:0] m_gpr_mem [NGPR];
    bit          s_busy_pre, s_accept, s_is_gpr, s_is_csr;
    logic [2:0]  s_err;
    logic [15:0] s_rn;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_busy = 0; m_kind = 0; m_cmderr = 3'd0; m_data0out = 32'd0;
            m_addr = 12'd0; m_gpr = 0; m_regin = 32'd0; e_drw = 0; e_we = 0;
        end else begin
            cyc++;
            s_busy_pre = m_busy;
            s_accept   = CmdValid && !s_busy_pre && (m_cmderr == 3'd0);
            s_err = 3'd0; e_drw = 0; e_we = 0;
            if (m_busy && cyc == m_k + 1) begin
                s_rn     = m_cmd[15:0];
                s_is_gpr = (s_rn >= 16'h1000) && (s_rn < 16'(16'h1000 + NGPR));
                s_is_csr = (s_rn < 16'h1000);
                if (m_cmd[31:24] != 8'd0)                    s_err = 3'd2;
                else if (m_cmd[17] && m_cmd[22:20] != 3'd2)  s_err = 3'd2;
                else if (m_cmd[17] && !s_is_gpr && !s_is_csr) s_err = 3'd2;
                else if (!DebugMode)                         s_err = 3'd4;
                if (s_err != 3'd0 || !m_cmd[17]) begin
                    m_end = m_k + 2;
                end else begin
                    m_addr = s_is_gpr ? 12'(s_rn - 16'h1000) : s_rn[11:0];
                    m_gpr  = s_is_gpr;
                    m_kind = m_cmd[16] ? 1 : 2;
                    m_end  = m_k + (m_cmd[16] ? 3 : 2 + RL);
                end
            end
            if (m_busy && m_kind == 1 && cyc == m_k + 1) begin
                e_drw = 1; m_regin = m_data0;
                if (m_gpr && m_addr != 12'd0) m_gpr_mem[m_addr[4:0]] = m_data0;
            end
            if (m_busy && m_kind == 2 && cyc == m_k + 1 + RL) begin
                e_we = 1;
                m_data0out = m_gpr ? m_gpr_mem[m_addr[4:0]] : csr_val(m_addr);
            end
            if (m_busy && cyc == m_end) m_busy = 0;
            if (s_err == 3'd0 && CmdValid && s_busy_pre) s_err = 3'd1;
            if (s_err != 3'd0 && m_cmderr == 3'd0) m_cmderr = s_err;
            else m_cmderr = m_cmderr & ~CmdErrClr;
            if (s_accept) begin
                m_busy = 1; m_k = cyc; m_end = cyc + 1000000; m_kind = 0;
                m_cmd = CmdWord; m_data0 = Data0In;
            end
        end
    end

    // ---------------- compare process + pulse monitors ----------------
    int          cnt_busy = 0, cnt_drw = 0, cnt_we = 0;
    logic [31:0] last_regin = 32'd0;
    always @(negedge clk) begin
        if (reset_n && cyc > 0) begin
            check("busy", {31'd0, Busy}, {31'd0, m_busy});
            check("cmderr", {29'd0, CmdErr}, {29'd0, m_cmderr});
            check("dbg_reg_write", {31'd0, DebugRegWrite}, {31'd0, e_drw});
            check("data0_we", {31'd0, Data0WE}, {31'd0, e_we});
            check("data0_out", Data0Out, m_data0out);
            if (e_drw) check("reg_in", RegIn, m_regin);
            if (m_busy && m_kind != 0 && cyc > m_k) begin
                check("reg_addr", {20'd0, RegAddr}, {20'd0, m_addr});
                check("reg_is_gpr", {31'd0, RegIsGPR}, {31'd0, m_gpr});
            end
            cnt_busy += int'(Busy);
            cnt_drw  += int'(DebugRegWrite);
            cnt_we   += int'(Data0WE);
            if (DebugRegWrite) last_regin = RegIn;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [31:0] make_cmd(input logic [7:0] ct, input logic [2:0] sz,
                                             input logic tr, input logic wr, input logic [15:0] rn);
        return {ct, 1'b0, sz, 2'b00, tr, wr, rn};
    endfunction

    task automatic issue(input logic [31:0] cmd, input logic [31:0] d0);
        tick();
        CmdValid = 1'b1; CmdWord = cmd; Data0In = d0;
        tick();
        CmdValid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40; i++) begin
            if (!Busy) break;
            tick();
        end
        check("idle_timeout", {31'd0, Busy}, 32'd0);
        tick();
    endtask

    task automatic clear_err();
        tick();
        CmdErrClr = 3'b111;
        tick();
        CmdErrClr = 3'b000;
    endtask

    function automatic logic [31:0] rand_cmd();
        int          kind;
        logic [2:0]  sz;
        kind = $urandom_range(0, 9);
        case (kind)
            0, 1, 2, 3: return make_cmd(8'd0, 3'd2, 1'b1, 1'($urandom), 16'(16'h1000 + $urandom_range(0, NGPR - 1)));
            4, 5:       return make_cmd(8'd0, 3'd2, 1'b1, 1'($urandom), 16'($urandom_range(0, 12'hFFF)));
            6:          return make_cmd(8'd0, 3'd2, 1'b1, 1'($urandom), 16'($urandom_range(16'h1000 + NGPR, 16'hFFFF)));
            7: begin
                sz = 3'($urandom_range(0, 6));
                if (sz >= 3'd2) sz = sz + 3'd1;
                return make_cmd(8'd0, sz, 1'b1, 1'($urandom), 16'h1001);
            end
            8:       return make_cmd(8'($urandom_range(1, 255)), 3'd2, 1'b1, 1'($urandom), 16'h1002);
            default: return make_cmd(8'd0, 3'd2, 1'b0, 1'($urandom), 16'($urandom));
        endcase
    endfunction

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        int b_busy, b_drw, b_we;
        for (int i = 0; i < NGPR; i++) begin
            core_gpr[i]  = gpr_init(i);
            m_gpr_mem[i] = gpr_init(i);
        end
        #12;
        check("rst_busy", {31'd0, Busy}, 32'd0);
        check("rst_cmderr", {29'd0, CmdErr}, 32'd0);
        check("rst_data0_out", Data0Out, 32'd0);
        check("rst_reg_addr", {20'd0, RegAddr}, 32'd0);
        check("rst_dbg_reg_write", {31'd0, DebugRegWrite}, 32'd0);
        tick();
        reset_n = 1'b1;
        DebugMode = 1'b1;
        tick();

        // GPR write x5
        b_busy = cnt_busy; b_drw = cnt_drw; b_we = cnt_we;
        issue(32'h0023_1005, 32'hDEAD_BEEF);
        wait_idle();
        check("wr_busy_cycles", 32'(cnt_busy - b_busy), 32'd3);
        check("wr_strobe_count", 32'(cnt_drw - b_drw), 32'd1);
        check("wr_no_data0_we", 32'(cnt_we - b_we), 32'd0);
        check("wr_reg_in", last_regin, 32'hDEAD_BEEF);
        check("wr_reg_addr", {20'd0, RegAddr}, 32'h005);
        check("wr_is_gpr", {31'd0, RegIsGPR}, 32'd1);
        check("wr_cmderr", {29'd0, CmdErr}, 32'd0);

        // CSR read 0x7B1
        b_busy = cnt_busy; b_drw = cnt_drw; b_we = cnt_we;
        issue(32'h0022_07B1, 32'h0);
        wait_idle();
        check("rd_busy_cycles", 32'(cnt_busy - b_busy), 32'd4);
        check("rd_we_count", 32'(cnt_we - b_we), 32'd1);
        check("rd_no_write", 32'(cnt_drw - b_drw), 32'd0);
        check("rd_data0_out", Data0Out, 32'h8000_0004);
        check("rd_reg_addr", {20'd0, RegAddr}, 32'h7B1);
        check("rd_is_gpr", {31'd0, RegIsGPR}, 32'd0);

        // Not halted
        DebugMode = 1'b0;
        b_busy = cnt_busy; b_drw = cnt_drw; b_we = cnt_we;
        issue(make_cmd(8'd0, 3'd2, 1'b1, 1'b0, 16'h1003), 32'h0);
        wait_idle();
        check("halt_cmderr", {29'd0, CmdErr}, 32'd4);
        check("halt_busy_cycles", 32'(cnt_busy - b_busy), 32'd2);
        check("halt_no_strobes", 32'(cnt_drw - b_drw + cnt_we - b_we), 32'd0);
        DebugMode = 1'b1;
        b_busy = cnt_busy; b_drw = cnt_drw;
        issue(make_cmd(8'd0, 3'd2, 1'b1, 1'b1, 16'h1003), 32'h0BAD_F00D);
        wait_idle();
        check("blocked_no_busy", 32'(cnt_busy - b_busy), 32'd0);
        check("blocked_no_write", 32'(cnt_drw - b_drw), 32'd0);
        check("blocked_cmderr", {29'd0, CmdErr}, 32'd4);
        clear_err();
        check("cleared_cmderr", {29'd0, CmdErr}, 32'd0);
        b_drw = cnt_drw;
        issue(make_cmd(8'd0, 3'd2, 1'b1, 1'b1, 16'h1003), 32'h0BAD_F00D);
        wait_idle();
        check("after_clear_write", 32'(cnt_drw - b_drw), 32'd1);
        check("after_clear_reg_in", last_regin, 32'h0BAD_F00D);

        // Unsupported commands
        issue(32'h0100_0000, 32'h0);
        wait_idle();
        check("cmdtype1_cmderr", {29'd0, CmdErr}, 32'd2);
        clear_err();
        issue(make_cmd(8'd0, 3'd3, 1'b1, 1'b0, 16'h1002), 32'h0);
        wait_idle();
        check("aarsize3_cmderr", {29'd0, CmdErr}, 32'd2);
        clear_err();

        // Busy collision: second command one cycle after the first
        b_drw = cnt_drw;
        tick();
        CmdValid = 1'b1; CmdWord = make_cmd(8'd0, 3'd2, 1'b1, 1'b1, 16'h1009); Data0In = 32'h1234_5678;
        tick();
        CmdWord = make_cmd(8'd0, 3'd2, 1'b1, 1'b1, 16'h100A); Data0In = 32'h5555_AAAA;
        tick();
        CmdValid = 1'b0;
        wait_idle();
        check("collide_cmderr", {29'd0, CmdErr}, 32'd1);
        check("collide_write_count", 32'(cnt_drw - b_drw), 32'd1);
        check("collide_reg_in", last_regin, 32'h1234_5678);
        check("collide_reg_addr", {20'd0, RegAddr}, 32'h009);
        clear_err();

        // Reset during READ_WAIT, then read x9 back
        b_we = cnt_we;
        issue(make_cmd(8'd0, 3'd2, 1'b1, 1'b0, 16'h1009), 32'h0);
        tick();
        reset_n = 1'b0;
        #1;
        check("mid_rst_busy", {31'd0, Busy}, 32'd0);
        check("mid_rst_data0_we", {31'd0, Data0WE}, 32'd0);
        check("mid_rst_data0_out", Data0Out, 32'd0);
        check("mid_rst_reg_addr", {20'd0, RegAddr}, 32'd0);
        check("mid_rst_is_gpr", {31'd0, RegIsGPR}, 32'd0);
        check("mid_rst_reg_in", RegIn, 32'd0);
        check("mid_rst_dbg_wr", {31'd0, DebugRegWrite}, 32'd0);
        check("mid_rst_cmderr", {29'd0, CmdErr}, 32'd0);
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        check("mid_rst_no_we", 32'(cnt_we - b_we), 32'd0);
        issue(make_cmd(8'd0, 3'd2, 1'b1, 1'b0, 16'h1009), 32'h0);
        wait_idle();
        check("post_rst_read_x9", Data0Out, 32'h1234_5678);

        // Randomized traffic against the model
        for (int i = 0; i < 800; i++) begin
            tick();
            CmdValid  = ($urandom_range(0, 3) == 0);
            CmdWord   = rand_cmd();
            Data0In   = $urandom;
            DebugMode = ($urandom_range(0, 9) != 0);
            CmdErrClr = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
        end
        tick();
        CmdValid = 1'b0;
        CmdErrClr = 3'd0;
        wait_idle();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
